data_port_arbiter: RTL
======================

DATA_PORT_ARBITER -- requirements
Module: data_port_arbiter

Interface
REQ-001 SHALL have parameter READ_LAT, default 1, cycles from mem_en (read) to mem_rdata valid; legal range 1..3.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, consecutive cycles a pending debug read is refused before it is forced; legal range 1..15.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port cpu_req  input  1  CPU data access request, held until cpu_stall low.
REQ-006 SHALL have port cpu_we  input  1  1 = write, 0 = read; valid with cpu_req.
REQ-007 SHALL have ports cpu_addr, cpu_wdata  input  32 each  CPU address and write data.
REQ-008 SHALL have ports cpu_rdata (32), cpu_rvalid (1), cpu_stall (1)  output  read data, one-cycle read-return strobe, hold-request indicator.
REQ-009 SHALL have ports dbg_req (1), dbg_addr (32)  input  FPGA readout read request and address; read-only requester.
REQ-010 SHALL have ports dbg_rdata (32), dbg_rvalid (1), dbg_busy (1)  output  readout data, strobe, hold-request indicator.
REQ-011 SHALL have ports mem_en (1), mem_we (1), mem_addr (32), mem_wdata (32)  output  data-cache port drive.
REQ-012 SHALL have port mem_rdata  input  32  data-cache read data.

Function
REQ-013 SHALL implement states IDLE, CPU_RD, DBG_RD; exactly one access in flight, no pipelining.
REQ-014 In IDLE with one request pending, SHALL grant it that cycle: mem_en=1, mem_addr/mem_we/mem_wdata from the granted requester.
REQ-015 With both pending in IDLE, SHALL grant CPU unless the starvation counter equals STARVE_LIMIT, then grant debug.
REQ-016 CPU write SHALL complete in its grant cycle: mem_we=1, cpu_stall=0 that cycle, state stays IDLE.
REQ-017 Read grant SHALL move to CPU_RD/DBG_RD and load latency counter with READ_LAT; mem_en=0 while waiting.
REQ-018 Requester rdata SHALL capture mem_rdata exactly READ_LAT cycles after the grant edge, with rvalid=1 for that one cycle; state returns to IDLE that cycle; the next grant may occur in the following cycle.
REQ-019 cpu_stall SHALL equal cpu_req AND NOT (write granted this cycle OR cpu_rvalid this cycle); dbg_busy likewise with dbg_rvalid.
REQ-020 rdata registers SHALL hold their last value between strobes.
REQ-021 A request deasserted mid-read SHALL NOT abort the read; rvalid still pulses.
REQ-022 Starvation counter SHALL increment each cycle dbg_req=1 and debug not granted, saturate at STARVE_LIMIT, clear on debug grant or dbg_req=0.
REQ-023 Addresses and data SHALL pass through unmodified at 32 bits; no alignment check.

Reset
REQ-024 On reset assertion, regardless of clk, SHALL force state IDLE, counters 0, mem_en=mem_we=0, mem_addr=mem_wdata=0, rvalids=0, rdata=0.
REQ-025 Reset mid-read SHALL discard the in-flight read; no rvalid after reset release.
REQ-026 First grant SHALL occur no earlier than the first rising clk after reset deasserts.

Configuration
REQ-027 Macro DPA_STARVE_GUARD_EN defined: starvation counter and forced debug grant per REQ-015/REQ-022 present.
REQ-028 DPA_STARVE_GUARD_EN undefined: no counter, strict CPU priority; debug granted only when cpu_req=0 in IDLE; STARVE_LIMIT ignored.

Verification
REQ-029 READ_LAT=1, CPU read addr 0x10, mem_rdata=0xDEADBEEF -> mem_en one cycle, cpu_rvalid next cycle, cpu_rdata=0xDEADBEEF, cpu_stall 1 then 0.
REQ-030 CPU write addr 0x20 data 0x12345678 -> mem_en=mem_we=1, mem_addr=0x20, mem_wdata=0x12345678 same cycle, cpu_stall=0.
REQ-031 Guard enabled, STARVE_LIMIT=4, dbg_req and back-to-back CPU reads held -> debug granted at the first IDLE once counter=4, dbg_rvalid with correct data, then CPU resumes.
REQ-032 Guard disabled, same stimulus -> dbg_busy stays 1, zero debug grants until cpu_req drops, then debug granted next IDLE cycle.
REQ-033 READ_LAT=3, reset pulse 1 cycle after CPU read grant -> all outputs 0 immediately, no cpu_rvalid afterwards, next request served normally.

Source files
------------

// File: rtl/data_port_arbiter.sv
// Arbitrates one data-cache port between the CPU and the read-only FPGA readout requester.
// Optional macro DPA_STARVE_GUARD_EN adds a starvation counter that forces a debug grant.
module data_port_arbiter #(
    parameter int unsigned READ_LAT     = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_rvalid,
    output logic        cpu_stall,
    input  logic        dbg_req,
    input  logic [31:0] dbg_addr,
    output logic [31:0] dbg_rdata,
    output logic        dbg_rvalid,
    output logic        dbg_busy,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned LAT_W    = 2;
    localparam int unsigned STARVE_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CPU_RD = 2'd1,
        DBG_RD = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [LAT_W-1:0]    lat_q;
    logic [LAT_W-1:0]    lat_d;
    logic [DATA_W-1:0]   cpu_rdata_q;
    logic [DATA_W-1:0]   dbg_rdata_q;
    logic                cpu_grant;
    logic                dbg_grant;
    logic                force_dbg;

`ifdef DPA_STARVE_GUARD_EN
    logic [STARVE_W-1:0] starve_q;

    // Counts cycles a pending debug read is passed over; saturates at the limit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_q <= '0;
        end else if (!dbg_req || dbg_grant) begin
            starve_q <= '0;
        end else if (starve_q != STARVE_W'(STARVE_LIMIT)) begin
            starve_q <= starve_q + STARVE_W'(1);
        end
    end

    assign force_dbg = (starve_q == STARVE_W'(STARVE_LIMIT));
`else
    logic [STARVE_W-1:0] unused_starve_limit;

    assign unused_starve_limit = STARVE_W'(STARVE_LIMIT);
    assign force_dbg           = 1'b0;
`endif

    // State and latency counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
        end
    end

    // Arbitration, memory port drive and read-return strobes.
    always_comb begin
        state_d    = state_q;
        lat_d      = lat_q;
        cpu_grant  = 1'b0;
        dbg_grant  = 1'b0;
        cpu_rvalid = 1'b0;
        dbg_rvalid = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;

        case (state_q)
            IDLE: begin
                if (!reset) begin
                    if (cpu_req && !(dbg_req && force_dbg)) begin
                        cpu_grant = 1'b1;
                    end else if (dbg_req) begin
                        dbg_grant = 1'b1;
                    end
                end
                if (cpu_grant) begin
                    mem_en    = 1'b1;
                    mem_we    = cpu_we;
                    mem_addr  = cpu_addr;
                    mem_wdata = cpu_wdata;
                    if (!cpu_we) begin
                        state_d = CPU_RD;
                        lat_d   = LAT_W'(READ_LAT);
                    end
                end else if (dbg_grant) begin
                    mem_en   = 1'b1;
                    mem_addr = dbg_addr;
                    state_d  = DBG_RD;
                    lat_d    = LAT_W'(READ_LAT);
                end
            end
            CPU_RD: begin
                if (lat_q == LAT_W'(1)) begin
                    cpu_rvalid = 1'b1;
                    state_d    = IDLE;
                    lat_d      = '0;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            DBG_RD: begin
                if (lat_q == LAT_W'(1)) begin
                    dbg_rvalid = 1'b1;
                    state_d    = IDLE;
                    lat_d      = '0;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                lat_d   = '0;
            end
        endcase
    end

    // Returned data is captured on the strobe cycle and held until the next one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            if (cpu_rvalid) begin
                cpu_rdata_q <= mem_rdata;
            end
            if (dbg_rvalid) begin
                dbg_rdata_q <= mem_rdata;
            end
        end
    end

    // Strobe cycle forwards memory data so rdata is valid alongside rvalid.
    assign cpu_rdata = cpu_rvalid ? mem_rdata : cpu_rdata_q;
    assign dbg_rdata = dbg_rvalid ? mem_rdata : dbg_rdata_q;

    assign cpu_stall = cpu_req & ~((cpu_grant & cpu_we) | cpu_rvalid);
    assign dbg_busy  = dbg_req & ~dbg_rvalid;

endmodule
